div_controller: RTL and testbench

//  - Control FSM that sits directly upstream of the 8-bit division datapath.
//  - Accepts one divide request per valid/ready handshake.
//  - Sequences the datapath strobes (start, shift, load, out) through N restoring iterations.
//  - Presents completion to the consumer through a valid/ready result handshake.

---
 rtl/div_controller.sv | 145 ++++++++++++++
 tb/tb_div_controller.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/div_controller.sv
// rtl/div_controller.sv - sequencing FSM for the restoring division datapath
//
// Purpose: accepts one divide request per req_valid/req_ready handshake, pulses
// start once, then alternates shift/load for N iterations, and presents the
// result through a res_valid/res_ready handshake while driving out.
//
// Ports:
//   clk, rst           single clock, synchronous active-high reset
//   req_valid/ready    request handshake (ready only in IDLE)
//   divisor            divisor bus, tapped for the zero check
//   start/shift/load   datapath strobes, mutually exclusive
//   out                datapath result-drive enable (DONE only)
//   iter               completed iteration count, stops at N
//   res_valid/ready    result handshake
//   div_zero           result is a divide-by-zero flag
//   busy               high in any state other than IDLE
//
// Configuration: define DIV_CTRL_ZERO_CHECK_EN to short-circuit a zero divisor
// straight to DONE with div_zero=1 and out=0. Undefined, divisor is ignored.

module div_controller #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [N-1:0]             divisor,
    output logic                     start,
    output logic                     shift,
    output logic                     load,
    output logic                     out,
    output logic [$clog2(N+1)-1:0]   iter,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     div_zero,
    output logic                     busy
);

    localparam int IW = $clog2(N + 1);
    localparam logic [IW-1:0] ITER_N = IW'(N);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        SUB,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          div_zero_q, div_zero_d;
    logic          req_ready_q, req_ready_d;
    logic          start_q, start_d;
    logic          shift_q, shift_d;
    logic          load_q, load_d;
    logic          out_q, out_d;
    logic          res_valid_q, res_valid_d;
    logic          busy_q, busy_d;
    logic          zero_req;

`ifdef DIV_CTRL_ZERO_CHECK_EN
    assign zero_req = (divisor == '0);
`else
    logic unused_divisor;
    assign zero_req       = 1'b0;
    assign unused_divisor = ^divisor;
`endif

    always_comb begin
        state_d    = state_q;
        iter_d     = iter_q;
        div_zero_d = div_zero_q;
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    iter_d     = '0;
                    div_zero_d = zero_req;
                    state_d    = zero_req ? DONE : START;
                end
            end
            START: state_d = SHIFT;
            SHIFT: state_d = SUB;
            SUB: begin
                iter_d  = iter_q + IW'(1);
                state_d = (iter_q + IW'(1) == ITER_N) ? DONE : SHIFT;
            end
            DONE: begin
                if (res_ready) begin
                    state_d    = IDLE;
                    div_zero_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered: decode them from the state being entered.
        req_ready_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        start_d     = (state_d == START);
        shift_d     = (state_d == SHIFT);
        load_d      = (state_d == SUB);
        res_valid_d = (state_d == DONE);
        // A zero-divisor result leaves the datapath buses undriven.
        out_d       = (state_d == DONE) && !div_zero_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            iter_q      <= '0;
            div_zero_q  <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            start_q     <= 1'b0;
            shift_q     <= 1'b0;
            load_q      <= 1'b0;
            out_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            div_zero_q  <= div_zero_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            start_q     <= start_d;
            shift_q     <= shift_d;
            load_q      <= load_d;
            out_q       <= out_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign start     = start_q;
    assign shift     = shift_q;
    assign load      = load_q;
    assign out       = out_q;
    assign res_valid = res_valid_q;
    assign iter      = iter_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_controller.sv
// tb/tb_div_controller.sv - randomized self-checking bench for div_controller

module tb_div_controller;

    localparam int N      = 8;
    localparam int IW     = $clog2(N + 1);
    localparam int DONE_K = 2 * N + 2;
`ifdef DIV_CTRL_ZERO_CHECK_EN
    localparam bit ZCHK = 1'b1;
`else
    localparam bit ZCHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [N-1:0]  divisor;
    logic          start;
    logic          shift;
    logic          load;
    logic          out;
    logic [IW-1:0] iter;
    logic          res_valid;
    logic          res_ready;
    logic          div_zero;
    logic          busy;

    div_controller #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .divisor   (divisor),
        .start     (start),
        .shift     (shift),
        .load      (load),
        .out       (out),
        .iter      (iter),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .div_zero  (div_zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Transaction-level model: m_k counts cycles since the accepting edge
    // (cycle 1 = start pulse). m_idle_iter is the iter value held in IDLE.
    bit m_busy      = 1'b0;
    bit m_zero      = 1'b0;
    int m_k         = 0;
    int m_idle_iter = 0;

    // Called at a negedge: check current outputs, drive inputs for the next
    // posedge, advance the model across that edge, then wait for next negedge.
    task automatic step(input bit rv, input logic [N-1:0] dv, input bit rr,
                        input bit rs, input bit chk);
        bit e_start, e_shift, e_load, e_done, e_out, e_dz;
        int e_iter;
        bit done_now;
        if (chk) begin
            e_start = 0; e_shift = 0; e_load = 0; e_done = 0; e_out = 0; e_dz = 0;
            e_iter  = m_idle_iter;
            if (m_busy && m_zero) begin
                e_done = 1; e_dz = 1; e_iter = 0;
            end else if (m_busy) begin
                e_start = (m_k == 1);
                e_shift = (m_k >= 2) && (m_k <= 2 * N + 1) && (m_k % 2 == 0);
                e_load  = (m_k >= 3) && (m_k <= 2 * N + 1) && (m_k % 2 == 1);
                e_done  = (m_k >= DONE_K);
                e_out   = e_done;
                e_iter  = e_done ? N : ((m_k < 2) ? 0 : (m_k - 2) / 2);
            end
            check("req_ready", 32'(req_ready), 32'(!m_busy));
            check("busy",      32'(busy),      32'(m_busy));
            check("start",     32'(start),     32'(e_start));
            check("shift",     32'(shift),     32'(e_shift));
            check("load",      32'(load),      32'(e_load));
            check("out",       32'(out),       32'(e_out));
            check("res_valid", 32'(res_valid), 32'(e_done));
            check("div_zero",  32'(div_zero),  32'(e_dz));
            check("iter",      32'(iter),      32'(e_iter));
        end
        rst       = rs;
        req_valid = rv;
        divisor   = dv;
        res_ready = rr;
        if (rs) begin
            m_busy = 0; m_zero = 0; m_k = 0; m_idle_iter = 0;
        end else if (!m_busy) begin
            if (rv) begin
                m_busy = 1; m_k = 1; m_zero = ZCHK && (dv == '0);
            end
        end else begin
            done_now = m_zero || (m_k >= DONE_K);
            if (done_now && rr) begin
                m_busy      = 0;
                m_idle_iter = m_zero ? 0 : N;
            end else if (!done_now) begin
                m_k++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drain(input bit rr);
        for (int i = 0; i < 60 && m_busy; i++) step(0, N'($urandom), rr, 0, 1);
        check("drain_bound", 32'(m_busy), 32'(0));
    endtask

    initial begin
        rst = 1; req_valid = 0; divisor = '0; res_ready = 0;
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 0);

        // Plain request, divisor 7, no backpressure.
        step(1, N'(7), 1, 0, 1);
        drain(1);

        // Backpressure: hold res_ready low for 5 cycles in DONE.
        step(1, N'(5), 0, 0, 1);
        for (int i = 0; i < 40 && m_k < DONE_K; i++) step(0, N'(5), 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, N'(5), 0, 0, 1);
        drain(1);

        // Reset during the SUB cycle where iter=3, then a fresh request.
        step(1, N'(3), 1, 0, 1);
        for (int i = 0; i < 40 && m_k != 9; i++) step(0, N'(3), 1, 0, 1);
        step(0, N'(3), 1, 1, 1);
        step(0, N'(3), 1, 0, 1);
        step(1, N'(9), 1, 0, 1);
        drain(1);

        // Zero divisor (short path only when the zero check is built in).
        step(1, '0, 1, 0, 1);
        drain(1);

        // Randomized traffic: requests while busy, backpressure, rare resets.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom % 2) == 1,
                 ($urandom % 4 == 0) ? '0 : N'($urandom),
                 ($urandom % 10) < 7,
                 ($urandom % 200) == 0,
                 1);
        end
        drain(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
